uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Buffered UART receive path: it takes the serial line driven by `UART_TX`, detects the start bit, samples each bit at mid-bit, and checks the stop bit. Good bytes go into a small FIFO that the host drains with a valid/ready handshake. It sits between the external RX pin and the host logic, and adds glitch rejection, framing and overrun reporting, and buffering. Default timing is the 25 MHz / 115200 baud system rate.

## Interface
Parameters:
- `CLKS_PER_BIT`, 217: clocks per serial bit; must be ≥ 4.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, ≥ 2.

Ports:
- `i_Clock` in 1: system clock. One clock; all state on its rising edge.
- `i_Rst_L` in 1: reset, asynchronous and active-low.
- `i_RX_Serial` in 1: raw serial line, idle high, LSB first.
- `i_RX_Ready` in 1: host accepts the head byte.
- `o_RX_DV` out 1: FIFO non-empty.
- `o_RX_Byte` out 8: FIFO head entry; 8'h00 when empty.
- `o_Frame_Err` out 1: one-cycle pulse when the stop bit is sampled low.
- `o_Overrun` out 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `o_Parity_Err` out 1: one-cycle pulse on a parity mismatch; tied 0 without the macro.
- `o_RX_Busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- `i_RX_Serial` passes through a 2-FF synchronizer. Both flops reset to 1. Everything below uses the synchronized line (`rx_s`).
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE:
  - `rx_s`=0 → START, bit counter cleared.
- START:
  - Waits `H`=(CLKS_PER_BIT-1)/2 clocks, then resamples.
  - 0 → DATA; 1 → IDLE (glitch, no flags).
- DATA:
  - Samples once every CLKS_PER_BIT clocks, 8 times, shifting LSB first.
  - → PARITY or STOP.
- PARITY: samples one bit, compares against even parity of the data byte, → STOP.
- STOP: samples one bit.
  - 1, parity ok: push the byte. If the FIFO is full and no pop occurs this cycle, drop the byte and pulse `o_Overrun`. → IDLE.
  - 1, parity bad: no push, pulse `o_Parity_Err`, → IDLE.
  - 0: no push, pulse `o_Frame_Err` (takes priority over parity), → BREAK.
- BREAK: waits for `rx_s`=1, then → IDLE.
- FIFO:
  - Pop on `o_RX_DV && i_RX_Ready`.
  - Push and pop in the same cycle are both accepted. When full, this is not an overrun.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with a count of width clog2(FIFO_DEPTH)+1.
- Reset (asynchronous, including mid-frame):
  - FSM → IDLE, FIFO emptied, counters 0, synchronizer flops 1.
  - All outputs 0 (`o_RX_Byte`=8'h00).

## Timing
- T0 = the rising edge at which IDLE first sees `rx_s`=0. This is 2 clocks after the pin falls.
- Start check at T0+H (T0+108 at default).
- Data bit k (k = 0..7) sampled at T0+H+(k+1)·CLKS_PER_BIT.
- Stop bit sampled, and push performed, at:
  - T0+H+9·CLKS_PER_BIT (T0+2061) without the macro;
  - T0+H+10·CLKS_PER_BIT (T0+2278) with it.
- Registered outputs, so flags and the DV/byte change appear at the edge after the sample:
  - `o_RX_DV` rises at push+1. `o_RX_Byte` is valid at the same edge.
  - Error pulses occur at sample+1 and last exactly 1 cycle.
- A pop updates `o_RX_Byte`/`o_RX_DV` on the next edge. The host may hold `i_RX_Ready` high continuously.
- Back-to-back frames: the next start bit is accepted in the cycle after the return to IDLE.

## Configuration
- `UART_RX_PARITY_EN` defined: an even-parity bit is expected between D7 and stop. PARITY state and `o_Parity_Err` are active.
- Not defined: 8N1 frames. No PARITY state; `o_Parity_Err` is tied 0.

## Test plan
- Send 0x37 8N1 at 217 clocks/bit, `i_RX_Ready`=0 → `o_RX_DV` rises at T0+2062, `o_RX_Byte`=8'h37. Raise ready for 1 cycle → `o_RX_DV`=0, byte=8'h00.
- Drive the line low for 50 clocks, then high → no DV, no flags. `o_RX_Busy` high for ≈108 clocks, then low.
- Send 0x55 with the stop bit forced low, line held low 500 clocks → single-cycle `o_Frame_Err`, no push. `o_RX_Busy` stays high until the line rises.
- With ready=0, send 0x01–0x05 back-to-back → `o_Overrun` pulses once, on byte 5. Draining yields 01, 02, 03, 04, then empty.
- Assert `i_Rst_L`=0 during data bit 3 of a frame → all outputs 0 immediately. After release, 0xA5 is received correctly.
- With `UART_RX_PARITY_EN`: send 0x37 with parity bit 1 → byte received at T0+2279. Resend with parity bit 0 → `o_Parity_Err` pulse, no push.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Buffered UART receiver (8 data bits, LSB first, 1 stop bit). Optional even
// parity bit between D7 and stop when UART_RX_PARITY_EN is defined.
// Good bytes are queued in a small FIFO that the host drains.
//
// Ports:
//   i_Clock      system clock, all state on its rising edge
//   i_Rst_L      asynchronous active-low reset
//   i_RX_Serial  raw serial line (idle high)
//   i_RX_Ready   host accepts the head byte
//   o_RX_DV      FIFO non-empty
//   o_RX_Byte    FIFO head byte, 8'h00 when empty
//   o_Frame_Err  1-cycle pulse: stop bit sampled low
//   o_Overrun    1-cycle pulse: good byte dropped, FIFO full
//   o_Parity_Err 1-cycle pulse: parity mismatch (0 without UART_RX_PARITY_EN)
//   o_RX_Busy    receiver FSM not idle
//
// Host handshake: a byte transfers on every rising edge where o_RX_DV and
// i_RX_Ready are both high; o_RX_DV/o_RX_Byte then present the next entry
// after that same edge, so i_RX_Ready may stay high continuously.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_RX_Serial,
    input  logic       i_RX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_Frame_Err,
    output logic       o_Overrun,
    output logic       o_Parity_Err,
    output logic       o_RX_Busy
);
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NW   = AW + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_e;

    // Two-flop synchronizer, reset to the idle (high) line level.
    logic sync1_q, rx_s_q;
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= i_RX_Serial;
            rx_s_q  <= sync1_q;
        end
    end

    // Receive FSM. Results of the stop-bit sample are registered (push_q,
    // *_pend_q) and acted on one edge later by the FIFO/output stage.
    state_e        state_q;
    logic [CW-1:0] clk_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          push_q;
    logic [7:0]    push_byte_q;
    logic          frame_pend_q;
`ifdef UART_RX_PARITY_EN
    logic          parity_bad_q;
    logic          parity_pend_q;
`endif

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q       <= S_IDLE;
            clk_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            push_q        <= 1'b0;
            push_byte_q   <= '0;
            frame_pend_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q  <= 1'b0;
            parity_pend_q <= 1'b0;
`endif
        end else begin
            push_q        <= 1'b0;
            frame_pend_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_pend_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    clk_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    if (!rx_s_q) state_q <= S_START;
                end
                S_START: begin
                    // Resample near mid start bit; a high line means a glitch.
                    if (clk_cnt_q == HALF_LAST) begin
                        clk_cnt_q <= '0;
                        state_q   <= rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q    <= '0;
                        // Even parity: the received bit must equal XOR of data.
                        parity_bad_q <= (rx_s_q != ^shift_q);
                        state_q      <= S_STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        if (!rx_s_q) begin
                            frame_pend_q <= 1'b1;
                            state_q      <= S_BREAK;
                        end
`ifdef UART_RX_PARITY_EN
                        else if (parity_bad_q) begin
                            parity_pend_q <= 1'b1;
                            state_q       <= S_IDLE;
                        end
`endif
                        else begin
                            push_q      <= 1'b1;
                            push_byte_q <= shift_q;
                            state_q     <= S_IDLE;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s_q) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // FIFO
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          rx_dv_q, fifo_full, pop, push_ok;
    logic [7:0]    head_d;

    always_comb begin
        fifo_full = (count_q == NW'(FIFO_DEPTH));
        pop       = rx_dv_q && i_RX_Ready;
        // A simultaneous pop frees the slot, so a full FIFO still accepts.
        push_ok   = push_q && (!fifo_full || pop);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Next head: the byte being written this edge if it lands at the new
        // read slot, otherwise what is already stored there.
        if (count_d == '0)
            head_d = 8'h00;
        else if (push_ok && (rd_ptr_d == wr_ptr_q))
            head_d = push_byte_q;
        else
            head_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge i_Clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_byte_q;
    end

    logic [7:0] rx_byte_q;
    logic       frame_err_q, overrun_q;
`ifdef UART_RX_PARITY_EN
    logic       parity_err_q;
`endif

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rx_dv_q      <= 1'b0;
            rx_byte_q    <= 8'h00;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rx_dv_q      <= (count_d != '0);
            rx_byte_q    <= head_d;
            frame_err_q  <= frame_pend_q;
            overrun_q    <= push_q && fifo_full && !pop;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_pend_q;
`endif
        end
    end

    assign o_RX_DV     = rx_dv_q;
    assign o_RX_Byte   = rx_byte_q;
    assign o_Frame_Err = frame_err_q;
    assign o_Overrun   = overrun_q;
    assign o_RX_Busy   = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign o_Parity_Err = parity_err_q;
`else
    assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo at the default 217 clocks/bit, depth 4.
// Builds for both 8N1 and UART_RX_PARITY_EN (8E1) configurations.
module tb_uart_rx_fifo;
    localparam int CPB   = 217;
    localparam int H     = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam int EXTRA = CPB;
`else
    localparam int EXTRA = 0;
`endif
    // Cycles from the negedge the start bit is driven to the edge where the
    // received byte (or a stop-bit flag) first shows on the outputs:
    // 3 (sync + idle detect) + H + 9 bit periods + 1 registered output.
    localparam int LAT   = 3 + H + 9 * CPB + 1 + EXTRA;

    // ---------------- clock / reset ----------------
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       pin   = 1'b1;
    logic       ready = 1'b0;
    logic       o_RX_DV, o_Frame_Err, o_Overrun, o_Parity_Err, o_RX_Busy;
    logic [7:0] o_RX_Byte;
    int         cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .i_Clock      (clk),
        .i_Rst_L      (rst_n),
        .i_RX_Serial  (pin),
        .i_RX_Ready   (ready),
        .o_RX_DV      (o_RX_DV),
        .o_RX_Byte    (o_RX_Byte),
        .o_Frame_Err  (o_Frame_Err),
        .o_Overrun    (o_Overrun),
        .o_Parity_Err (o_Parity_Err),
        .o_RX_Busy    (o_RX_Busy)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    // ---------------- output event monitor (negedge sampling) ----------------
    int   dv_rise_n = 0, dv_rise_cyc = 0;
    int   fe_hi_n = 0, fe_cyc = 0;
    int   ov_hi_n = 0, ov_cyc = 0;
    int   pe_hi_n = 0, pe_cyc = 0;
    int   busy_hi_n = 0;
    logic dv_prev = 1'b0;

    always @(negedge clk) begin
        if (o_RX_DV && !dv_prev) begin
            dv_rise_n   = dv_rise_n + 1;
            dv_rise_cyc = cyc;
        end
        dv_prev = o_RX_DV;
        if (o_Frame_Err)  begin fe_hi_n = fe_hi_n + 1; fe_cyc = cyc; end
        if (o_Overrun)    begin ov_hi_n = ov_hi_n + 1; ov_cyc = cyc; end
        if (o_Parity_Err) begin pe_hi_n = pe_hi_n + 1; pe_cyc = cyc; end
        if (o_RX_Busy)    busy_hi_n = busy_hi_n + 1;
    end

    // ---------------- driver tasks (call at a negedge) ----------------
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int stop_len);
        pin = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            pin = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        pin = (^d) ^ par_flip;
        repeat (CPB) @(negedge clk);
`endif
        pin = stop_b;
        repeat (stop_len) @(negedge clk);
        pin = 1'b1;
    endtask

    task automatic pulse_ready();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    // Compares the head against each queued byte, pops it, then expects empty.
    task automatic drain_and_check(input string name);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (o_RX_DV !== 1'b1 || o_RX_Byte !== e) begin
                errors++;
                $display("FAIL %s drain: dv=%b byte=%02h, required dv=1 byte=%02h", name, o_RX_DV, o_RX_Byte, e);
            end
            pulse_ready();
        end
        checks++;
        if (o_RX_DV !== 1'b0 || o_RX_Byte !== 8'h00) begin
            errors++;
            $display("FAIL %s empty: dv=%b byte=%02h, required dv=0 byte=00", name, o_RX_DV, o_RX_Byte);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({o_RX_DV, o_RX_Byte, o_Frame_Err, o_Overrun, o_Parity_Err, o_RX_Busy} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: dv=%b byte=%02h fe=%b ov=%b pe=%b busy=%b, required all 0",
                     o_RX_DV, o_RX_Byte, o_Frame_Err, o_Overrun, o_Parity_Err, o_RX_Busy);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (o_RX_DV !== 1'b0 || o_RX_Busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: dv=%b busy=%b, required 0 0", o_RX_DV, o_RX_Busy);
        end
    endtask

    task automatic test_single_byte();
        int c0, r0, f0, p0;
        c0 = cyc; r0 = dv_rise_n; f0 = fe_hi_n; p0 = pe_hi_n;
        send_frame(8'h37, 1'b1, CPB);
        repeat (20) @(negedge clk);
        checks++;
        if (dv_rise_n - r0 != 1 || dv_rise_cyc != c0 + LAT) begin
            errors++;
            $display("FAIL single_dv_timing: rises=%0d at +%0d, required 1 at +%0d", dv_rise_n - r0, dv_rise_cyc - c0, LAT);
        end
        checks++;
        if (o_RX_DV !== 1'b1 || o_RX_Byte !== 8'h37) begin
            errors++;
            $display("FAIL single_byte: dv=%b byte=%02h, required 1 37", o_RX_DV, o_RX_Byte);
        end
        checks++;
        if (o_RX_Busy !== 1'b0 || fe_hi_n != f0 || pe_hi_n != p0) begin
            errors++;
            $display("FAIL single_flags: busy=%b fe=%0d pe=%0d, required 0 0 0", o_RX_Busy, fe_hi_n - f0, pe_hi_n - p0);
        end
        pulse_ready();
        checks++;
        if (o_RX_DV !== 1'b0 || o_RX_Byte !== 8'h00) begin
            errors++;
            $display("FAIL single_pop: dv=%b byte=%02h, required 0 00", o_RX_DV, o_RX_Byte);
        end
    endtask

    task automatic test_glitch();
        int r0, f0, b0;
        r0 = dv_rise_n; f0 = fe_hi_n + ov_hi_n + pe_hi_n; b0 = busy_hi_n;
        pin = 1'b0;
        repeat (50) @(negedge clk);
        pin = 1'b1;
        repeat (200) @(negedge clk);
        checks++;
        if (busy_hi_n - b0 != H) begin
            errors++;
            $display("FAIL glitch_busy: busy cycles=%0d, required %0d", busy_hi_n - b0, H);
        end
        checks++;
        if (dv_rise_n != r0 || (fe_hi_n + ov_hi_n + pe_hi_n) != f0 || o_RX_Busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_quiet: dv rises=%0d flags=%0d busy=%b, required 0 0 0",
                     dv_rise_n - r0, fe_hi_n + ov_hi_n + pe_hi_n - f0, o_RX_Busy);
        end
    endtask

    task automatic test_frame_error();
        int c0, r0, f0;
        c0 = cyc; r0 = dv_rise_n; f0 = fe_hi_n;
        send_frame(8'h55, 1'b0, 500);
        checks++;
        if (o_RX_Busy !== 1'b1) begin
            errors++;
            $display("FAIL break_busy: busy=%b while line low, required 1", o_RX_Busy);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (fe_hi_n - f0 != 1 || fe_cyc != c0 + LAT) begin
            errors++;
            $display("FAIL frame_err_pulse: high cycles=%0d at +%0d, required 1 at +%0d", fe_hi_n - f0, fe_cyc - c0, LAT);
        end
        checks++;
        if (dv_rise_n != r0 || o_RX_DV !== 1'b0 || o_RX_Busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_nopush: dv rises=%0d dv=%b busy=%b, required 0 0 0", dv_rise_n - r0, o_RX_DV, o_RX_Busy);
        end
    endtask

    task automatic test_overrun();
        int c5, o0;
        o0 = ov_hi_n;
        c5 = 0;
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) c5 = cyc;
            send_frame(8'(i), 1'b1, CPB);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (ov_hi_n - o0 != 1 || ov_cyc != c5 + LAT) begin
            errors++;
            $display("FAIL overrun_pulse: high cycles=%0d at +%0d, required 1 at +%0d", ov_hi_n - o0, ov_cyc - c5, LAT);
        end
        checks++;
        if (o_RX_DV !== 1'b1 || o_RX_Byte !== 8'h01) begin
            errors++;
            $display("FAIL overrun_head: dv=%b byte=%02h, required 1 01", o_RX_DV, o_RX_Byte);
        end
    endtask

    // FIFO holds 01..04; the push of 06 coincides with a pop of 01.
    task automatic test_full_push_pop();
        int o0;
        o0 = ov_hi_n;
        fork
            send_frame(8'h06, 1'b1, CPB);
            begin
                repeat (LAT - 1) @(negedge clk);
                pulse_ready();
            end
        join
        repeat (20) @(negedge clk);
        checks++;
        if (ov_hi_n != o0) begin
            errors++;
            $display("FAIL full_push_pop_overrun: pulses=%0d, required 0", ov_hi_n - o0);
        end
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h06);
        drain_and_check("full_push_pop");
        // Popping an empty FIFO must change nothing.
        ready = 1'b1;
        repeat (3) @(negedge clk);
        ready = 1'b0;
        checks++;
        if (o_RX_DV !== 1'b0 || o_RX_Byte !== 8'h00) begin
            errors++;
            $display("FAIL empty_pop: dv=%b byte=%02h, required 0 00", o_RX_DV, o_RX_Byte);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int c0, r0, p0;
        c0 = cyc; r0 = dv_rise_n; p0 = pe_hi_n;
        par_flip = 1'b1;
        send_frame(8'h37, 1'b1, CPB);
        par_flip = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (pe_hi_n - p0 != 1 || pe_cyc != c0 + LAT) begin
            errors++;
            $display("FAIL parity_err_pulse: high cycles=%0d at +%0d, required 1 at +%0d", pe_hi_n - p0, pe_cyc - c0, LAT);
        end
        checks++;
        if (dv_rise_n != r0 || o_RX_DV !== 1'b0) begin
            errors++;
            $display("FAIL parity_nopush: dv rises=%0d dv=%b, required 0 0", dv_rise_n - r0, o_RX_DV);
        end
    endtask
`else
    task automatic test_parity();
        checks++;
        if (pe_hi_n != 0 || o_RX_Parity_tie_bad()) begin
            errors++;
            $display("FAIL parity_tied: pulses=%0d now=%b, required 0 0", pe_hi_n, o_Parity_Err);
        end
    endtask
    function automatic logic o_RX_Parity_tie_bad();
        return (o_Parity_Err !== 1'b0);
    endfunction
`endif

    task automatic test_reset_mid_frame();
        int c0, r0;
        logic [7:0] d;
        send_frame(8'h3C, 1'b1, CPB);
        repeat (10) @(negedge clk);
        d = 8'hA5;
        pin = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            pin = d[i];
            repeat (CPB) @(negedge clk);
        end
        pin = d[3];
        repeat (100) @(negedge clk);
        checks++;
        if (o_RX_Busy !== 1'b1 || o_RX_DV !== 1'b1 || o_RX_Byte !== 8'h3C) begin
            errors++;
            $display("FAIL pre_reset_state: busy=%b dv=%b byte=%02h, required 1 1 3C", o_RX_Busy, o_RX_DV, o_RX_Byte);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_RX_DV, o_RX_Byte, o_Frame_Err, o_Overrun, o_Parity_Err, o_RX_Busy} !== 13'h0) begin
            errors++;
            $display("FAIL async_reset: dv=%b byte=%02h fe=%b ov=%b pe=%b busy=%b, required all 0",
                     o_RX_DV, o_RX_Byte, o_Frame_Err, o_Overrun, o_Parity_Err, o_RX_Busy);
        end
        @(negedge clk);
        pin = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        c0 = cyc; r0 = dv_rise_n;
        send_frame(8'hA5, 1'b1, CPB);
        repeat (20) @(negedge clk);
        checks++;
        if (dv_rise_n - r0 != 1 || dv_rise_cyc != c0 + LAT) begin
            errors++;
            $display("FAIL after_reset_timing: rises=%0d at +%0d, required 1 at +%0d", dv_rise_n - r0, dv_rise_cyc - c0, LAT);
        end
        exp_q.push_back(8'hA5);
        drain_and_check("after_reset");
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_full_push_pop();
        test_parity();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
